// File: rtl/serial_lut_subtractor_if.sv
// rtl/serial_lut_subtractor_if.sv - start/done handshake and operand/result bundle for the serial subtractor
//
// Purpose: groups the request, operand and result signals of serial_lut_subtractor
// so the requester and the arithmetic unit connect through one port.
// Signals:
//   start  request; sampled only while the subtractor is idle
//   a      minuend, captured on an accepted start
//   b      subtrahend, captured on an accepted start
//   busy   high while bits are being processed
//   done   one-cycle pulse, d/bout (and ovf) valid
//   d      difference, held until the next accepted start
//   bout   unsigned borrow (a < b), held with d
//   ovf    signed overflow, present only when SERSUB_OVF_EN is defined
// Modports: master drives the request side, slave is the subtractor.

interface serial_lut_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SERSUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, d, bout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, bout, ovf
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, bout
  );
`endif
endinterface

// File: rtl/serial_lut_subtractor.sv
// rtl/serial_lut_subtractor.sv - bit-serial LUT3 subtractor computing D = A - B, LSB first
//
// Purpose: one LUT3 full-adder cell plus a carry flip-flop evaluates A + ~B + 1 one bit
// per clock. A start/done handshake frames each operation; the unit runs WIDTH cycles,
// then pulses done for one cycle with the difference and the unsigned borrow.
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous, active-high reset
//   bus    serial_lut_subtractor_if.slave (start/a/b in, busy/done/d/bout[/ovf] out)
// Configuration macro SERSUB_OVF_EN: when defined, adds the ovf output (signed
// two's-complement overflow), captured together with bout and cleared by the next
// accepted start. When undefined there is no ovf port and no ovf flip-flop.

module serial_lut_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  serial_lut_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Truth tables of the LUT3 cell, indexed by {a0, ~b0, carry}:
  // sum is the odd-parity function, carry-out the majority function.
  localparam logic [7:0] LUT_SUM   = 8'h96;
  localparam logic [7:0] LUT_CARRY = 8'hE8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
`ifdef SERSUB_OVF_EN
  logic             r_ovf;
`endif

  logic [2:0] w_lut_idx;
  logic       w_sum;
  logic       w_cout;

  // Inverting b0 at the cell input and seeding the carry with 1 turns the adder into A - B.
  assign w_lut_idx = {r_a[0], ~r_b[0], r_carry};
  assign w_sum     = LUT_SUM[w_lut_idx];
  assign w_cout    = LUT_CARRY[w_lut_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERSUB_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_d     <= '0;
            r_count <= '0;
            r_carry <= 1'b1;
            r_bout  <= 1'b0;
            r_busy  <= 1'b1;
`ifdef SERSUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // Result bits enter at the MSB so the first (LSB) bit ends up at d[0].
          r_d     <= {w_sum, r_d[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_cout;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_BIT) begin
            // Borrow/overflow are taken from the MSB cell on the way into FIN so
            // they are already valid during the done cycle.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bout  <= ~w_cout;
`ifdef SERSUB_OVF_EN
            r_ovf   <= r_carry ^ w_cout;
`endif
            r_state <= S_FIN;
          end
        end

        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.d    = r_d;
  assign bus.bout = r_bout;
`ifdef SERSUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_lut_subtractor.sv
// tb/tb_serial_lut_subtractor.sv - directed self-checking bench for serial_lut_subtractor

module tb_serial_lut_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_lut_subtractor_if #(.WIDTH(W)) u_if ();

  serial_lut_subtractor #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits on falling edges for done; first is the index of the next falling edge
  // counted from the accepting rising edge. lat = -1 when the budget runs out.
  task automatic wait_done(input int first, output int lat, output int overlap);
    lat     = -1;
    overlap = 0;
    for (int n = first; n <= 40; n++) begin
      @(negedge clk);
      if (u_if.busy && u_if.done) overlap++;
      if (u_if.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_bout, input logic exp_ovf);
    int lat;
    int overlap;
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.a     = a;
    u_if.b     = b;
    @(negedge clk);
    u_if.start = 1'b0;
    // Operands change right after capture and must not affect the result.
    u_if.a     = ~a;
    u_if.b     = a ^ b;
    check({tag, "_busy"}, 32'(u_if.busy), 32'd1);
    wait_done(2, lat, overlap);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_d"}, 32'(u_if.d), 32'(exp_d));
    check({tag, "_bout"}, 32'(u_if.bout), 32'(exp_bout));
`ifdef SERSUB_OVF_EN
    check({tag, "_ovf"}, 32'(u_if.ovf), 32'(exp_ovf));
`endif
    $display("op %s: a=%02h b=%02h d=%02h bout=%0b (expected ovf %0b)",
             tag, a, b, u_if.d, u_if.bout, exp_ovf);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(u_if.done), 32'd0);
    check({tag, "_d_held"}, 32'(u_if.d), 32'(exp_d));
  endtask

  initial begin
    int lat;
    int overlap;
    int extra_done;

    rst        = 1'b1;
    u_if.start = 1'b0;
    u_if.a     = '0;
    u_if.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_done", 32'(u_if.done), 32'd0);
    check("rst_d",    32'(u_if.d),    32'd0);
    check("rst_bout", 32'(u_if.bout), 32'd0);
`ifdef SERSUB_OVF_EN
    check("rst_ovf",  32'(u_if.ovf),  32'd0);
`endif
    rst = 1'b0;

    run_op("s05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("s03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("s80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("s7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op("s00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("sff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("s00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

    // START held high through RUN while the operands keep changing.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.a     = 8'h5A;
    u_if.b     = 8'h21;
    lat        = -1;
    overlap    = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (u_if.busy && u_if.done) overlap++;
      if (u_if.done) begin
        lat = n;
        break;
      end
      u_if.a = 8'(n * 37);
      u_if.b = 8'(8'hC3 ^ n);
    end
    check("hold_latency", 32'(lat), 32'd9);
    check("hold_overlap", 32'(overlap), 32'd0);
    check("hold_d", 32'(u_if.d), 32'h39);
    check("hold_bout", 32'(u_if.bout), 32'd0);
    // FIN -> IDLE cycle: no second pulse, not yet busy; present the second operands.
    @(negedge clk);
    check("hold_single_done", 32'(u_if.done), 32'd0);
    check("hold_idle_gap", 32'(u_if.busy), 32'd0);
    u_if.a = 8'h10;
    u_if.b = 8'h20;
    @(negedge clk);
    check("hold_second_busy", 32'(u_if.busy), 32'd1);
    u_if.start = 1'b0;
    wait_done(2, lat, overlap);
    check("hold2_latency", 32'(lat), 32'd9);
    check("hold2_d", 32'(u_if.d), 32'hF0);
    check("hold2_bout", 32'(u_if.bout), 32'd1);
`ifdef SERSUB_OVF_EN
    check("hold2_ovf", 32'(u_if.ovf), 32'd0);
`endif

    // Reset four cycles into RUN aborts the operation without a done pulse.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.a     = 8'hC3;
    u_if.b     = 8'h3C;
    @(negedge clk);
    u_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(u_if.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(u_if.busy), 32'd0);
    check("abort_done", 32'(u_if.done), 32'd0);
    check("abort_d",    32'(u_if.d),    32'd0);
    check("abort_bout", 32'(u_if.bout), 32'd0);
    extra_done = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (u_if.done || u_if.busy) extra_done++;
    end
    check("abort_no_done", 32'(extra_done), 32'd0);

    run_op("s64_0a", 8'h64, 8'h0A, 8'h5A, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
